// File: rtl/cavlc_block_sequencer_if.sv
// Bundle of signals between the CAVLC block sequencer, its four syntax-element
// decoders, the shared bitstream shifter and the block-level requester.
// Ports: master = sequencer side, slave = environment (decoders/shifter/requester).
interface cavlc_block_sequencer_if;
   // block request / status
   logic       Start;
   logic [4:0] MaxNumCoeff;
   logic       Abort;
   logic       Busy;
   logic       BlkDone;
   logic       Error;
   // stage enables
   logic       CtEnable;
   logic       LvEnable;
   logic       TzEnable;
   logic       RbEnable;
   // per-stage shift requests
   logic [4:0] CtNumShift;
   logic [4:0] LvNumShift;
   logic [4:0] TzNumShift;
   logic [4:0] RbNumShift;
   logic       CtShiftEn;
   logic       LvShiftEn;
   logic       TzShiftEn;
   logic       RbShiftEn;
   // stage completion and results
   logic       CtDone;
   logic       LvDone;
   logic       TzDone;
   logic       RbDone;
   logic [4:0] CtTotalCoeff;
   logic [1:0] CtTrailingOnes;
   logic [3:0] TzTotalZeros;
   // latched block parameters
   logic [4:0] TotalCoeff;
   logic [1:0] TrailingOnes;
   logic [3:0] TotalZeros;
   // shared shifter port
   logic [4:0] NumShift;
   logic       ShiftEn;

   modport master (
      input  Start, MaxNumCoeff, Abort,
      input  CtNumShift, LvNumShift, TzNumShift, RbNumShift,
      input  CtShiftEn, LvShiftEn, TzShiftEn, RbShiftEn,
      input  CtDone, LvDone, TzDone, RbDone,
      input  CtTotalCoeff, CtTrailingOnes, TzTotalZeros,
      output Busy, BlkDone, Error,
      output CtEnable, LvEnable, TzEnable, RbEnable,
      output TotalCoeff, TrailingOnes, TotalZeros,
      output NumShift, ShiftEn
   );

   modport slave (
      output Start, MaxNumCoeff, Abort,
      output CtNumShift, LvNumShift, TzNumShift, RbNumShift,
      output CtShiftEn, LvShiftEn, TzShiftEn, RbShiftEn,
      output CtDone, LvDone, TzDone, RbDone,
      output CtTotalCoeff, CtTrailingOnes, TzTotalZeros,
      input  Busy, BlkDone, Error,
      input  CtEnable, LvEnable, TzEnable, RbEnable,
      input  TotalCoeff, TrailingOnes, TotalZeros,
      input  NumShift, ShiftEn
   );
endinterface

// File: rtl/cavlc_block_sequencer.sv
// Sequences coeff_token -> levels -> total_zeros -> run_before for one CAVLC block,
// muxes the active stage onto the shared shifter, latches block parameters.
// Latency: Start -> CT enable next cycle; stage Done -> next enable next cycle (no gap).
// Backpressure: none; Start outside IDLE is dropped, stages hold until Done/timeout/Abort.
// Ports: Clk, nReset (async active-low), bus (master side of cavlc_block_sequencer_if).
module cavlc_block_sequencer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic                    Clk,
   input logic                    nReset,
   cavlc_block_sequencer_if.master bus
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CT, S_LV, S_TZ, S_RB, S_FINISH, S_ERR
   } state_t;

   state_t           state_q, state_d;
   logic [4:0]       max_q, max_d;
   logic [4:0]       tc_q, tc_d;
   logic [1:0]       t1_q, t1_d;
   logic [3:0]       tz_q, tz_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             in_stage;
   logic             stage_done;
   logic [4:0]       num_shift;
   logic             shift_en;
   logic [5:0]       coeff_sum;

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= S_IDLE;
         max_q   <= '0;
         tc_q    <= '0;
         t1_q    <= '0;
         tz_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         max_q   <= max_d;
         tc_q    <= tc_d;
         t1_q    <= t1_d;
         tz_q    <= tz_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      max_d      = max_q;
      tc_d       = tc_q;
      t1_d       = t1_q;
      tz_d       = tz_q;
      in_stage   = 1'b0;
      stage_done = 1'b0;
      num_shift  = '0;
      shift_en   = 1'b0;
      // 6-bit so that TotalZeros+TotalCoeff cannot wrap before the compare
      coeff_sum  = {2'b00, bus.TzTotalZeros} + {1'b0, tc_q};

      // select the active stage's shift request and completion flag
      unique case (state_q)
         S_CT: begin in_stage = 1'b1; stage_done = bus.CtDone; num_shift = bus.CtNumShift; shift_en = bus.CtShiftEn; end
         S_LV: begin in_stage = 1'b1; stage_done = bus.LvDone; num_shift = bus.LvNumShift; shift_en = bus.LvShiftEn; end
         S_TZ: begin in_stage = 1'b1; stage_done = bus.TzDone; num_shift = bus.TzNumShift; shift_en = bus.TzShiftEn; end
         S_RB: begin in_stage = 1'b1; stage_done = bus.RbDone; num_shift = bus.RbNumShift; shift_en = bus.RbShiftEn; end
         default: ;
      endcase

      unique case (state_q)
         S_IDLE: begin
            // Abort in IDLE blocks Start for that cycle
            if (bus.Start && !bus.Abort) begin
               state_d = S_CT;
               max_d   = bus.MaxNumCoeff;
               tc_d    = '0;
               t1_d    = '0;
               tz_d    = '0;
            end
         end
         S_FINISH, S_ERR: state_d = S_IDLE;
         default: begin
            // priority: Abort, then Done, then watchdog
            if (bus.Abort) begin
               state_d = S_IDLE;
            end else if (stage_done) begin
               unique case (state_q)
                  S_CT: begin
                     tc_d = bus.CtTotalCoeff;
                     t1_d = bus.CtTrailingOnes;
                     if (bus.CtTotalCoeff > max_q || {3'b000, bus.CtTrailingOnes} > bus.CtTotalCoeff)
                        state_d = S_ERR;
                     else if (bus.CtTotalCoeff == 5'd0)
                        state_d = S_FINISH;
                     else
                        state_d = S_LV;
                  end
                  S_LV: state_d = (tc_q == max_q) ? S_FINISH : S_TZ;
                  S_TZ: begin
                     tz_d = bus.TzTotalZeros;
                     if (coeff_sum > {1'b0, max_q})
                        state_d = S_ERR;
                     else if (bus.TzTotalZeros == 4'd0)
                        state_d = S_FINISH;
                     else
                        state_d = S_RB;
                  end
                  default: state_d = S_FINISH;
               endcase
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_ERR;
            end
         end
      endcase

      // stage age: restarts on every state change, counts only while a stage waits
      if (state_d != state_q || !in_stage)
         cnt_d = '0;
      else
         cnt_d = cnt_q + CNT_W'(1);
   end

   assign bus.Busy         = (state_q != S_IDLE);
   assign bus.BlkDone      = (state_q == S_FINISH);
   assign bus.Error        = (state_q == S_ERR);
   assign bus.CtEnable     = (state_q == S_CT);
   assign bus.LvEnable     = (state_q == S_LV);
   assign bus.TzEnable     = (state_q == S_TZ);
   assign bus.RbEnable     = (state_q == S_RB);
   assign bus.NumShift     = num_shift;
   assign bus.ShiftEn      = shift_en;
   assign bus.TotalCoeff   = tc_q;
   assign bus.TrailingOnes = t1_q;
   assign bus.TotalZeros   = tz_q;

endmodule

// File: doc/cavlc_block_sequencer.md
# cavlc_block_sequencer

Top-level sequencer for one CAVLC residual block. It steps the syntax-element decoders in order: coeff_token, levels, total_zeros, run_before. It owns the single shared bitstream shifter port by muxing the active stage's NumShift/ShiftEn onto it. It latches block parameters (TotalCoeff, TrailingOnes, TotalZeros) and distributes them to the downstream decoders. It also detects malformed blocks and hung stages.

## Interface
- TIMEOUT_CYCLES, 64, maximum cycles any one stage may stay enabled without asserting its Done.
- Clk  in  1  clock.
- nReset  in  1  reset, asynchronous, active-low.
- Start  in  1  block request; accepted only in IDLE.
- MaxNumCoeff  in  5  coefficients in this block type (16/15/4); sampled when Start is accepted.
- Abort  in  1  synchronous abort; returns to IDLE.
- Busy  out  1  high in every state except IDLE.
- BlkDone  out  1  one-cycle pulse, block decoded.
- Error  out  1  one-cycle pulse, block rejected.
- CtEnable / LvEnable / TzEnable / RbEnable  out  1 each  stage enables.
- CtNumShift, LvNumShift, TzNumShift, RbNumShift  in  5 each  stage shift requests.
- CtShiftEn, LvShiftEn, TzShiftEn, RbShiftEn  in  1 each  stage shift valids.
- CtDone, LvDone, TzDone, RbDone  in  1 each  stage-complete flags (combinational, last consuming cycle).
- CtTotalCoeff  in  5,  CtTrailingOnes  in  2  coeff_token results, valid with CtDone.
- TzTotalZeros  in  4  total_zeros result, valid with TzDone.
- TotalCoeff  out  5,  TrailingOnes  out  2,  TotalZeros  out  4  latched block parameters.
- NumShift  out  5,  ShiftEn  out  1  to bitstream shifter.

## Operation
- States: IDLE, CT, LV, TZ, RB, FINISH, ERR. Stage enables are Moore decodes: CtEnable=1 only in CT, LvEnable only in LV, TzEnable only in TZ, RbEnable only in RB.
- Shift mux: CT passes Ct*, LV passes Lv*, TZ passes Tz*, RB passes Rb*. All other states drive NumShift=0, ShiftEn=0.
- IDLE: Start=1 → CT; latch MaxNumCoeff; clear TotalCoeff, TrailingOnes, TotalZeros.
- CT, on CtDone:
  - Latch TotalCoeff and TrailingOnes.
  - If CtTotalCoeff>MaxNumCoeff or CtTrailingOnes>CtTotalCoeff → ERR.
  - Else if CtTotalCoeff==0 → FINISH.
  - Else → LV.
- LV, on LvDone: if TotalCoeff==MaxNumCoeff → FINISH (TotalZeros stays 0); else → TZ.
- TZ, on TzDone:
  - Latch TotalZeros.
  - If TzTotalZeros+TotalCoeff>MaxNumCoeff (6-bit compare) → ERR.
  - Else if TzTotalZeros==0 → FINISH.
  - Else → RB.
- RB, on RbDone → FINISH.
- FINISH: BlkDone=1 for one cycle → IDLE. ERR: Error=1 for one cycle → IDLE. Latched parameters hold until the next accepted Start.
- Watchdog:
  - StageCnt clears on every state transition.
  - In CT/LV/TZ/RB it increments each cycle that Done is low.
  - If StageCnt==TIMEOUT_CYCLES-1 and Done is low → ERR.
  - Done in that same cycle wins.
- Priority, highest first: Abort, then stage Done, then timeout.
- Abort in any non-IDLE state → IDLE next cycle, with no BlkDone and no Error. The shift of the abort cycle is still forwarded. Abort in IDLE is ignored and blocks Start that cycle.
- Start outside IDLE is ignored, not queued.

## Timing
- Reset values: state IDLE, Busy 0, BlkDone 0, Error 0, all enables 0, NumShift 0, ShiftEn 0, TotalCoeff/TrailingOnes/TotalZeros 0, StageCnt 0.
- Start accepted at edge k → CtEnable high from cycle k+1.
- A Done sampled at edge n → previous enable low and next enable high from cycle n+1. There is no gap cycle between stages, so each decoder sees Enable drop immediately after its last shift.
- Parameter outputs update at the edge that leaves the producing stage. They are therefore stable throughout every later stage.
- Minimum block (TotalCoeff=0): Start c0, CT c1 (CtDone), FINISH c2 (BlkDone), IDLE c3; next Start accepted in c3.
- Busy is high in the same cycles as any enable, FINISH and ERR.

## Test plan
- Empty block: MaxNumCoeff=16, CtDone in first CT cycle with TC=0 → BlkDone at c2. LvEnable/TzEnable/RbEnable never asserted. ShiftEn equals CtShiftEn only in c1.
- Full path: TC=5, T1=2, LvDone after 5 cycles, TzTotalZeros=3, RbDone after 2 cycles → enables sequence CT→LV→TZ→RB with no gaps. Outputs TotalCoeff=5, TrailingOnes=2, TotalZeros=3. One BlkDone.
- Full block: MaxNumCoeff=16, TC=16 → LV goes directly to FINISH. TzEnable never high. TotalZeros=0.
- Malformed: MaxNumCoeff=4, CtTotalCoeff=5 → ERR then Error pulse, no BlkDone. Separately, TC=10 with TzTotalZeros=7 at MaxNumCoeff=16 → Error.
- Watchdog: TIMEOUT_CYCLES=8, hold LvDone low → LvEnable high exactly 8 cycles, then Error pulse, then IDLE. Repeat with LvDone on the 8th cycle → no error, advances.
- Abort/reset: Abort in TZ with TzDone same cycle → IDLE next cycle, no BlkDone, no RB. nReset mid-LV → all outputs at reset values immediately.
